mips16_fetch_stage: RTL and testbench
=====================================

# mips16_fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the 16-bit pipelined MIPS datapath. Holds the program counter and drives the word address to instruction memory. Captures the returned instruction with its PC+1 into the IF/ID register. Applies stall, branch/jump redirect and flush requests from the downstream hazard and branch logic, and feeds the decode stage (control unit, register file, sign extend).

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0000, instruction word inserted into IF/ID on flush or bubble.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_addr  output  16  word address to instruction memory; combinational copy of the PC.
- imem_data  input  16  instruction word, combinational from memory, valid in the same cycle.
- stall  input  1  hazard unit: hold the PC and IF/ID.
- halt  input  1  request to stop fetching.
- resume  input  1  leave HALT.
- branch_taken  input  1  branch resolved taken in EX.
- branch_target  input  16  PC+1+offset from the branch adder.
- jump  input  1  jump decoded in ID.
- jump_target  input  16  jump address.
- pc  output  16  current PC.
- if_id_instr  output  16  registered instruction to decode.
- if_id_pc_inc  output  16  registered PC+1 of that instruction.
- if_id_valid  output  1  IF/ID holds a real instruction.
- fetch_state  output  2  current FSM state, for debug.

## Operation
- FSM states:
  - BOOT = 0: entered on reset; lasts exactly one cycle and fetches nothing.
  - RUN = 1: normal fetch.
  - HALT = 2: fetch stopped.
- Transitions:
  - BOOT -> RUN unconditionally.
  - RUN -> HALT when halt=1 and no redirect is pending.
  - HALT -> RUN when resume=1.
  - A redirect in HALT loads the PC but stays in HALT.
- Next-PC priority, highest first:
  1. reset -> RESET_PC.
  2. branch_taken -> branch_target (it is older than the jump in ID).
  3. jump -> jump_target.
  4. stall, or state is BOOT or HALT -> hold.
  5. Otherwise PC+1.
- PC+1 is 16-bit modulo arithmetic: 16'hFFFF + 1 = 16'h0000, with no overflow flag.
- IF/ID update:
  - branch_taken: flush. instr <= NOP_INSTR, valid <= 0, pc_inc <= 0.
  - jump (without branch_taken): flush the wrong-path word the same way.
  - stall: hold all IF/ID fields.
  - RUN, no stall, no redirect: instr <= imem_data, pc_inc <= PC+1, valid <= 1.
  - BOOT, or entering or remaining in HALT: insert a bubble (NOP_INSTR, valid 0).
- Redirect overrides stall: the PC loads the target and IF/ID is flushed even if stall=1.
- A halt asserted together with a redirect is ignored that cycle; halt must be held to take effect.

## Timing
- Reset values:
  - pc = RESET_PC, imem_addr = RESET_PC.
  - if_id_instr = NOP_INSTR, if_id_pc_inc = 0, if_id_valid = 0.
  - fetch_state = BOOT.
  - Counters (when enabled) = 0.
- Reset asserted mid-operation overrides every other input in that cycle.
- Fetch latency: an instruction at address A appears on if_id_instr one cycle after pc = A.
- First valid instruction: the first cycle after reset deasserts is BOOT and the PC holds. The word at RESET_PC is then fetched in the following cycle and appears in IF/ID one cycle later, so if_id_valid goes high 2 cycles after reset deasserts.
- Redirect penalty: one bubble. The target word is fetched in the cycle after the redirect edge.
- imem_addr changes only on clock edges, since it is a combinational copy of the PC register.

## Configuration
- MIPS16_FETCH_PERF_EN defined: adds two 16-bit outputs.
  - perf_fetched counts cycles that load a valid instruction into IF/ID.
  - perf_stalled counts cycles with stall=1 while in RUN.
  - Both wrap at 16 bits and clear on reset.
- Undefined: neither port nor counter exists; all other behaviour is identical.

## Structure
- Shared package mips16_pkg holds:
  - the state encoding (BOOT, RUN, HALT);
  - default constants RESET_PC_DEFAULT and NOP_INSTR;
  - the 16-bit word width constant.
- One sub-module, mips16_if_id_reg: IF/ID register with load, hold and flush controls and reset to NOP.
- The PC increment reuses the team's Full_Adder_2s_16Bits with Y=1 and cin=0.

## Test plan
- Reset release, memory word i = 16'h1000+i -> BOOT for one cycle, then if_id_instr = 16'h1000, 16'h1001, 16'h1002 on consecutive cycles with valid=1.
- stall=1 for 3 cycles with pc=5 -> pc stays 5, IF/ID holds the word at 4; fetch resumes at 5 with no lost or duplicated instruction.
- branch_taken=1, target=16'h0040, with stall=1 and jump=1 in the same cycle -> pc=16'h0040, one bubble (valid=0, instr=NOP), then the word at 16'h0040.
- pc=16'hFFFF in RUN -> next pc=16'h0000, if_id_pc_inc=16'h0000.
- halt=1 at pc=8 -> state HALT, pc stays 8, valid=0; resume=1 -> RUN, the word at 8 is fetched next.
- reset asserted mid-stream at pc=16'h0123 -> next edge: pc=RESET_PC, valid=0, state BOOT; with MIPS16_FETCH_PERF_EN, both counters read 0.

Source files
------------

// File: rtl/mips16_pkg.sv
// mips16_pkg: shared definitions for the 16-bit MIPS pipeline.
//   WORD_W           - datapath / instruction word width
//   RESET_PC_DEFAULT - default PC after reset
//   NOP_INSTR        - default bubble instruction word
//   fetch_state_e    - fetch FSM encoding (BOOT, RUN, HALT)
package mips16_pkg;
  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 16'h0000;
  localparam logic [WORD_W-1:0] NOP_INSTR        = 16'h0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/Full_Adder_2s_16Bits.sv
// Full_Adder_2s_16Bits: 16-bit two's-complement adder.
//   X, Y  - operands
//   cin   - carry in
//   S     - sum (modulo 2^16)
//   cout  - carry out
module Full_Adder_2s_16Bits (
  input  logic [15:0] X,
  input  logic [15:0] Y,
  input  logic        cin,
  output logic [15:0] S,
  output logic        cout
);
  assign {cout, S} = {1'b0, X} + {1'b0, Y} + {16'd0, cin};
endmodule

// File: rtl/mips16_if_id_reg.sv
// mips16_if_id_reg: IF/ID pipeline register.
//   clk_i, reset_i  - clock, synchronous active-high reset (clears to NOP)
//   load_i          - capture instr_i / pc_inc_i and mark valid
//   flush_i         - replace contents with a NOP bubble (wins over load_i)
//   instr_i, pc_inc_i - fetched word and its PC+1
//   instr_o, pc_inc_o, valid_o - registered outputs to decode
// Neither load nor flush holds the current contents.
module mips16_if_id_reg
  import mips16_pkg::*;
#(
  parameter logic [WORD_W-1:0] NOP_WORD = NOP_INSTR
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              load_i,
  input  logic              flush_i,
  input  logic [WORD_W-1:0] instr_i,
  input  logic [WORD_W-1:0] pc_inc_i,
  output logic [WORD_W-1:0] instr_o,
  output logic [WORD_W-1:0] pc_inc_o,
  output logic              valid_o
);
  logic [WORD_W-1:0] instr_q, pc_inc_q;
  logic              valid_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      instr_q  <= NOP_WORD;
      pc_inc_q <= '0;
      valid_q  <= 1'b0;
    end else if (load_i) begin
      instr_q  <= instr_i;
      pc_inc_q <= pc_inc_i;
      valid_q  <= 1'b1;
    end
  end

  assign instr_o  = instr_q;
  assign pc_inc_o = pc_inc_q;
  assign valid_o  = valid_q;
endmodule

// File: rtl/mips16_fetch_stage.sv
// mips16_fetch_stage: instruction fetch + IF/ID register.
//   clk, reset            - clock, synchronous active-high reset
//   imem_addr / imem_data - word address out, instruction word back (same cycle)
//   stall, halt, resume   - hazard hold, stop fetching, leave HALT
//   branch_taken/_target  - EX redirect (highest priority)
//   jump/jump_target      - ID redirect
//   pc, fetch_state       - current PC and FSM state (debug)
//   if_id_instr/_pc_inc/_valid - IF/ID contents to decode
// Optional feature macro MIPS16_FETCH_PERF_EN adds perf_fetched and
// perf_stalled 16-bit wrapping counters.
module mips16_fetch_stage #(
  parameter logic [15:0] RESET_PC  = mips16_pkg::RESET_PC_DEFAULT,
  parameter logic [15:0] NOP_INSTR = mips16_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        halt,
  input  logic        resume,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic        jump,
  input  logic [15:0] jump_target,
  output logic [15:0] pc,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc_inc,
  output logic        if_id_valid,
  output logic [1:0]  fetch_state
`ifdef MIPS16_FETCH_PERF_EN
  ,
  output logic [15:0] perf_fetched,
  output logic [15:0] perf_stalled
`endif
);
  import mips16_pkg::*;

  localparam logic [WORD_W-1:0] ONE = 16'h0001;

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d, pc_inc;
  logic              pc_carry_unused;
  logic              redirect, halt_take, ifid_load, ifid_flush;

  assign redirect  = branch_taken | jump;
  // A halt coinciding with a redirect is dropped; it must still be high next cycle.
  assign halt_take = (state_q == RUN) & halt & ~redirect;

  Full_Adder_2s_16Bits u_pc_inc (
    .X    (pc_q),
    .Y    (ONE),
    .cin  (1'b0),
    .S    (pc_inc),
    .cout (pc_carry_unused)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (halt_take) state_d = HALT;
      HALT:    if (resume) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // Entering HALT also holds the PC so the word at the halt point is the
  // first one fetched after resume.
  always_comb begin
    pc_d = pc_inc;
    if (branch_taken)                                 pc_d = branch_target;
    else if (jump)                                    pc_d = jump_target;
    else if (stall || (state_q != RUN) || halt_take)  pc_d = pc_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Redirect flushes even under stall; otherwise stall holds; a non-RUN or
  // halting cycle inserts a bubble.
  assign ifid_load  = ~redirect & ~stall & (state_q == RUN) & ~halt;
  assign ifid_flush = redirect | (~stall & ~ifid_load);

  mips16_if_id_reg #(.NOP_WORD(NOP_INSTR)) u_if_id (
    .clk_i    (clk),
    .reset_i  (reset),
    .load_i   (ifid_load),
    .flush_i  (ifid_flush),
    .instr_i  (imem_data),
    .pc_inc_i (pc_inc),
    .instr_o  (if_id_instr),
    .pc_inc_o (if_id_pc_inc),
    .valid_o  (if_id_valid)
  );

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign fetch_state = state_q;

`ifdef MIPS16_FETCH_PERF_EN
  logic [15:0] perf_fetched_q, perf_stalled_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_stalled_q <= '0;
    end else begin
      if (ifid_load)                 perf_fetched_q <= perf_fetched_q + 16'd1;
      if (stall && (state_q == RUN)) perf_stalled_q <= perf_stalled_q + 16'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stalled = perf_stalled_q;
`endif
endmodule

// File: tb/tb_mips16_fetch_stage.sv
module tb_mips16_fetch_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] imem_addr, imem_data;
  logic        stall = 1'b0, halt = 1'b0, resume = 1'b0;
  logic        branch_taken = 1'b0, jump = 1'b0;
  logic [15:0] branch_target = 16'h0, jump_target = 16'h0;
  logic [15:0] pc, if_id_instr, if_id_pc_inc;
  logic        if_id_valid;
  logic [1:0]  fetch_state;
`ifdef MIPS16_FETCH_PERF_EN
  logic [15:0] perf_fetched, perf_stalled;
`endif

  mips16_fetch_stage dut (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .halt(halt), .resume(resume),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .pc(pc), .if_id_instr(if_id_instr), .if_id_pc_inc(if_id_pc_inc),
    .if_id_valid(if_id_valid), .fetch_state(fetch_state)
`ifdef MIPS16_FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stalled(perf_stalled)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory: word at address A is 16'h1000 + A.
  assign imem_data = 16'h1000 + imem_addr;

  typedef struct {
    logic [15:0] pc;
    logic [1:0]  st;
    logic [15:0] instr;
    logic [15:0] pcinc;
    logic        valid;
    logic [15:0] pf;
    logic [15:0] ps;
  } exp_t;

  exp_t sbq[$];
  exp_t m;   // reference model state (expected DUT state after last edge)
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, predict the post-edge state, push it, then
  // pop and compare once the edge has happened.
  task automatic step(input logic rst, input logic stl, input logic hlt, input logic res,
                      input logic br, input logic [15:0] bt,
                      input logic jp, input logic [15:0] jt);
    exp_t e, g;
    logic redir, ld;
    logic [15:0] inc;
    reset = rst; stall = stl; halt = hlt; resume = res;
    branch_taken = br; branch_target = bt; jump = jp; jump_target = jt;
    redir = br | jp;
    inc   = m.pc + 16'd1;
    if (rst) begin
      e.pc = 16'h0; e.st = 2'd0; e.instr = 16'h0; e.pcinc = 16'h0;
      e.valid = 1'b0; e.pf = 16'h0; e.ps = 16'h0;
    end else begin
      case (m.st)
        2'd0:    e.st = 2'd1;
        2'd1:    e.st = (hlt && !redir) ? 2'd2 : 2'd1;
        default: e.st = res ? 2'd1 : 2'd2;
      endcase
      ld = !redir && !stl && (m.st == 2'd1) && !hlt;
      if (br)      e.pc = bt;
      else if (jp) e.pc = jt;
      else if (ld) e.pc = inc;
      else         e.pc = m.pc;
      if (redir || (!stl && !ld)) begin
        e.instr = 16'h0; e.pcinc = 16'h0; e.valid = 1'b0;
      end else if (stl) begin
        e.instr = m.instr; e.pcinc = m.pcinc; e.valid = m.valid;
      end else begin
        e.instr = 16'h1000 + m.pc; e.pcinc = inc; e.valid = 1'b1;
      end
      e.pf = m.pf + (ld ? 16'd1 : 16'd0);
      e.ps = m.ps + ((stl && m.st == 2'd1) ? 16'd1 : 16'd0);
    end
    m = e;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      g = sbq.pop_front();
      chk("pc", pc, g.pc);
      chk("imem_addr", imem_addr, g.pc);
      chk("state", fetch_state, g.st);
      chk("if_id_instr", if_id_instr, g.instr);
      chk("if_id_pc_inc", if_id_pc_inc, g.pcinc);
      chk("if_id_valid", if_id_valid, g.valid);
`ifdef MIPS16_FETCH_PERF_EN
      chk("perf_fetched", perf_fetched, g.pf);
      chk("perf_stalled", perf_stalled, g.ps);
`endif
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 16'h0, 0, 16'h0);
  endtask

  initial begin
    // Reset, then boot and stream from address 0.
    step(1, 0, 0, 0, 0, 16'h0, 0, 16'h0);
    step(1, 0, 0, 0, 0, 16'h0, 0, 16'h0);
    chk("rst_state", fetch_state, 2'd0);
    chk("rst_valid", if_id_valid, 1'b0);
    idle(1);
    chk("boot_valid", if_id_valid, 1'b0);
    chk("boot_pc", pc, 16'h0000);
    idle(1);
    chk("first_instr", if_id_instr, 16'h1000);
    chk("first_valid", if_id_valid, 1'b1);
    idle(2);
    chk("third_instr", if_id_instr, 16'h1002);
    idle(2);
    chk("pre_stall_pc", pc, 16'h0005);
    // Stall 3 cycles at pc=5.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 16'h0, 0, 16'h0);
    chk("stall_pc", pc, 16'h0005);
    chk("stall_instr", if_id_instr, 16'h1004);
    idle(1);
    chk("post_stall_instr", if_id_instr, 16'h1005);
    // Branch + jump + stall together: branch wins.
    step(0, 1, 0, 0, 1, 16'h0040, 1, 16'h0099);
    chk("br_pc", pc, 16'h0040);
    chk("br_bubble_valid", if_id_valid, 1'b0);
    chk("br_bubble_instr", if_id_instr, 16'h0000);
    idle(1);
    chk("br_target_instr", if_id_instr, 16'h1040);
    // Wrap at 16'hFFFF.
    step(0, 0, 0, 0, 0, 16'h0, 1, 16'hFFFF);
    idle(1);
    chk("wrap_pc", pc, 16'h0000);
    chk("wrap_pc_inc", if_id_pc_inc, 16'h0000);
    chk("wrap_instr", if_id_instr, 16'h0FFF);
    // Halt at pc=8, then resume.
    step(0, 0, 0, 0, 0, 16'h0, 1, 16'h0008);
    step(0, 0, 1, 0, 0, 16'h0, 0, 16'h0);
    chk("halt_state", fetch_state, 2'd2);
    chk("halt_pc", pc, 16'h0008);
    idle(2);
    step(0, 0, 0, 0, 0, 16'h0, 1, 16'h0030);
    chk("halt_redirect_state", fetch_state, 2'd2);
    step(0, 0, 0, 0, 0, 16'h0, 1, 16'h0008);
    step(0, 0, 0, 1, 0, 16'h0, 0, 16'h0);
    chk("resume_state", fetch_state, 2'd1);
    idle(1);
    chk("resume_instr", if_id_instr, 16'h1008);
    // Halt together with a redirect is ignored.
    step(0, 0, 1, 0, 0, 16'h0, 1, 16'h0020);
    chk("halt_ign_state", fetch_state, 2'd1);
    // Mid-stream reset at pc=0x0123.
    step(0, 0, 0, 0, 0, 16'h0, 1, 16'h0123);
    idle(2);
    step(1, 1, 1, 0, 1, 16'h0777, 1, 16'h0555);
    chk("mid_rst_pc", pc, 16'h0000);
    chk("mid_rst_state", fetch_state, 2'd0);
    idle(3);
    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 60) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 9) == 0), 16'($urandom),
           ($urandom_range(0, 9) == 0), 16'($urandom));
    end
    idle(2);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
